// File: rtl/nco_phase_acc.sv
// rtl/nco_phase_acc.sv - phase-accumulator NCO front end with linear-chirp FSM
// Optional feature macro: DITHER_EN (LFSR phase dither before truncation).
module nco_phase_acc #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 10,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               en,
  input  logic               clear,
  input  logic [ACC_W-1:0]   ftw_in,
  input  logic               ftw_load,
  output logic               ftw_ack,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic               sweep_start,
  input  logic [ACC_W-1:0]   sweep_step,
  input  logic [LEN_W-1:0]   sweep_len,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic [PHASE_W-1:0] a,
  output logic               a_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   ftw_q, ftw_d;
  logic [ACC_W-1:0]   step_q, step_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] a_q, a_d;
  logic               a_valid_q, a_valid_d;
  logic               ftw_ack_q, ftw_ack_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               active;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   phase_src;
  logic [PHASE_W-1:0] a_next;

  // A non-idle state only advances while en is high, so dropping en freezes
  // the accumulator on the very edge that leaves RUN or SWEEP.
  assign active  = en && (state_q != IDLE);
  assign acc_sum = acc_q + ftw_q;

`ifdef DITHER_EN
  localparam int DW = ACC_W - PHASE_W;

  logic [15:0]      lfsr_q, lfsr_d;
  logic [ACC_W-1:0] dither;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  always_comb begin
    lfsr_d = lfsr_q;
    if (active) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign dither    = {{PHASE_W{1'b0}}, lfsr_q[DW-1:0]};
  assign phase_src = acc_q + dither;
`else
  assign phase_src = acc_q;
`endif

  assign a_next = phase_src[ACC_W-1 -: PHASE_W] + phase_off;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    ftw_d     = ftw_q;
    ftw_ack_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (sweep_start && (sweep_len != '0) && !ftw_load) begin
          state_d = SWEEP;
          cnt_d   = sweep_len;
          step_d  = sweep_step;
        end
      end
      SWEEP: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          ftw_d = ftw_q + step_q;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loads stall while sweeping and land on the first cycle back out.
    if ((state_q != SWEEP) && ftw_load) begin
      ftw_d     = ftw_in;
      ftw_ack_d = 1'b1;
    end

    acc_d     = active ? acc_sum : acc_q;
    a_d       = active ? a_next : a_q;
    a_valid_d = active;
    if (clear) acc_d = '0;

    busy_d = (state_d == SWEEP);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      ftw_q     <= '0;
      step_q    <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      ftw_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ftw_q     <= ftw_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      ftw_ack_q <= ftw_ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign a          = a_q;
  assign a_valid    = a_valid_q;
  assign ftw_ack    = ftw_ack_q;
  assign sweep_busy = busy_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// tb/tb_nco_phase_acc.sv - directed, table-driven bench for nco_phase_acc
module tb_nco_phase_acc;

  logic        clk;
  logic        areset;
  logic        en;
  logic        clear;
  logic [23:0] ftw_in;
  logic        ftw_load;
  logic        ftw_ack;
  logic [9:0]  phase_off;
  logic        sweep_start;
  logic [23:0] sweep_step;
  logic [15:0] sweep_len;
  logic        sweep_busy;
  logic        sweep_done;
  logic [9:0]  a;
  logic        a_valid;

  int checks = 0;
  int errors = 0;

  nco_phase_acc #(.ACC_W(24), .PHASE_W(10), .LEN_W(16)) dut (
    .clk(clk), .areset(areset), .en(en), .clear(clear),
    .ftw_in(ftw_in), .ftw_load(ftw_load), .ftw_ack(ftw_ack),
    .phase_off(phase_off), .sweep_start(sweep_start), .sweep_step(sweep_step),
    .sweep_len(sweep_len), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .a(a), .a_valid(a_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clear;
    logic [9:0] ph;
    logic [9:0] exp_a;
    logic       exp_v;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, done_idx, ack_idx, ack_busy;

    // Offset / clear / enable table, starting from acc=0, ftw=24'h040000.
    tbl[0]  = '{1'b1, 1'b0, 10'h18E, 10'd398,  1'b1};
    tbl[1]  = '{1'b1, 1'b0, 10'h18E, 10'd414,  1'b1};
    tbl[2]  = '{1'b1, 1'b0, 10'h18E, 10'd430,  1'b1};
    tbl[3]  = '{1'b1, 1'b0, 10'h390, 10'd960,  1'b1};
    tbl[4]  = '{1'b1, 1'b0, 10'h390, 10'd976,  1'b1};
    tbl[5]  = '{1'b1, 1'b0, 10'h390, 10'd992,  1'b1};
    tbl[6]  = '{1'b1, 1'b0, 10'h390, 10'd1008, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 10'h390, 10'd0,    1'b1};
    tbl[8]  = '{1'b1, 1'b0, 10'h390, 10'd16,   1'b1};
    tbl[9]  = '{1'b1, 1'b0, 10'h3FF, 10'd143,  1'b1};
    tbl[10] = '{1'b1, 1'b1, 10'h3FF, 10'd159,  1'b1};
    tbl[11] = '{1'b1, 1'b0, 10'h3FF, 10'd1023, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 10'h3FF, 10'd1023, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 10'h000, 10'd1023, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 10'h000, 10'd16,   1'b1};
    tbl[15] = '{1'b1, 1'b0, 10'h005, 10'd37,   1'b1};

    areset = 1'b1; en = 1'b0; clear = 1'b0; ftw_in = '0; ftw_load = 1'b0;
    phase_off = '0; sweep_start = 1'b0; sweep_step = '0; sweep_len = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_ack", 32'(ftw_ack), 32'd0);
    chk("rst_busy", 32'(sweep_busy), 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    areset = 1'b0;

    // Load ftw and run a full phase wrap
    ftw_in = 24'h040000; ftw_load = 1'b1; en = 1'b1;
    step();
    chk("load_ack", 32'(ftw_ack), 32'd1);
    chk("load_valid0", 32'(a_valid), 32'd0);
    ftw_load = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      step();
      chk($sformatf("ramp_a_%0d", k), 32'(a), 32'((16 * (k - 1)) % 1024));
      chk($sformatf("ramp_v_%0d", k), 32'(a_valid), 32'd1);
      if (k == 1) chk("ack_single", 32'(ftw_ack), 32'd0);
    end

    // Phase offset table
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; clear = tbl[i].clear; phase_off = tbl[i].ph;
      step();
      chk($sformatf("tbl_a_%0d", i), 32'(a), 32'(tbl[i].exp_a));
      chk($sformatf("tbl_v_%0d", i), 32'(a_valid), 32'(tbl[i].exp_v));
    end
    clear = 1'b0;

    // Sweep from ftw=0, step 0x400, len 4
    ftw_in = 24'h0; ftw_load = 1'b1; clear = 1'b1; phase_off = 10'h0;
    step();
    chk("ftw0_ack", 32'(ftw_ack), 32'd1);
    ftw_load = 1'b0; clear = 1'b0;
    sweep_start = 1'b1; sweep_len = 16'd0;
    step();
    chk("len0_ignored", 32'(sweep_busy), 32'd0);
    sweep_len = 16'd4; sweep_step = 24'h000400;
    step();
    chk("sweep_busy_start", 32'(sweep_busy), 32'd1);
    chk("sweep_done_start", 32'(sweep_done), 32'd0);
    sweep_start = 1'b0; sweep_len = 16'd9; sweep_step = 24'hFFFFFF;
    busy_cnt = 1; done_cnt = 0; done_idx = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (sweep_busy) busy_cnt++;
      if (sweep_done) begin done_cnt++; done_idx = i; end
    end
    chk("sweep_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("sweep_done_count", 32'(done_cnt), 32'd1);
    chk("sweep_done_when", 32'(done_idx), 32'd4);
    chk("sweep_back_run", 32'(a_valid), 32'd1);
    // Final ramped ftw 0x1000 advances the angle by one every 4 samples
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 5)  chk("ftw_1000_k5", 32'(a), 32'd1);
      if (k == 17) chk("ftw_1000_k17", 32'(a), 32'd4);
    end

    // Load held during a sweep stalls until the sweep ends
    sweep_step = 24'h000400; sweep_len = 16'd3; sweep_start = 1'b1;
    step();
    sweep_start = 1'b0; ftw_load = 1'b1; ftw_in = 24'h040000;
    ack_idx = -1; done_idx = -1; ack_busy = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sweep_busy && ftw_ack) ack_busy++;
      if (sweep_done) done_idx = i;
      if (ftw_ack) begin ack_idx = i; break; end
    end
    chk("stall_ack_in_sweep", 32'(ack_busy), 32'd0);
    chk("stall_done_idx", 32'(done_idx), 32'd3);
    chk("stall_ack_idx", 32'(ack_idx), 32'd4);
    ftw_load = 1'b0; clear = 1'b1;
    step();
    chk("stall_ack_pulse", 32'(ftw_ack), 32'd0);
    clear = 1'b0;
    step();
    step();
    step();
    chk("stall_new_ftw", 32'(a), 32'd32);

    // Load and start together: load wins
    ftw_load = 1'b1; ftw_in = 24'h080000; sweep_start = 1'b1;
    sweep_len = 16'd4; sweep_step = 24'h000400; clear = 1'b1;
    step();
    chk("both_ack", 32'(ftw_ack), 32'd1);
    chk("both_no_busy", 32'(sweep_busy), 32'd0);
    ftw_load = 1'b0; sweep_start = 1'b0; clear = 1'b0;
    step();
    chk("both_no_busy2", 32'(sweep_busy), 32'd0);
    step();
    chk("both_a1", 32'(a), 32'd32);
    step();
    chk("both_a2", 32'(a), 32'd64);

    // Abort a sweep with en=0
    clear = 1'b1; sweep_start = 1'b1; sweep_len = 16'd10; sweep_step = 24'h000400;
    step();
    clear = 1'b0; sweep_start = 1'b0;
    step();
    chk("abort_x1", 32'(a), 32'd0);
    step();
    chk("abort_x2", 32'(a), 32'd32);
    step();
    chk("abort_x3", 32'(a), 32'd64);
    chk("abort_busy_pre", 32'(sweep_busy), 32'd1);
    en = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (sweep_done) done_cnt++;
      chk($sformatf("abort_a_%0d", i), 32'(a), 32'd64);
      chk($sformatf("abort_v_%0d", i), 32'(a_valid), 32'd0);
      chk($sformatf("abort_busy_%0d", i), 32'(sweep_busy), 32'd0);
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    phase_off = 10'd3; en = 1'b1;
    step();
    chk("reen_v0", 32'(a_valid), 32'd0);
    step();
    chk("reen_held_acc", 32'(a), 32'd99);

    // Clear while idle, then first sample equals phase_off
    en = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0; en = 1'b1; phase_off = 10'h155;
    step();
    chk("clr_v0", 32'(a_valid), 32'd0);
    chk("clr_a_hold", 32'(a), 32'd99);
    step();
    chk("clr_first_a", 32'(a), 32'h155);
    chk("clr_first_v", 32'(a_valid), 32'd1);

    // Asynchronous reset in the middle of a sweep with a load pending
    sweep_start = 1'b1; sweep_len = 16'd5; sweep_step = 24'h000400;
    step();
    sweep_start = 1'b0;
    step();
    chk("mid_busy", 32'(sweep_busy), 32'd1);
    ftw_load = 1'b1; ftw_in = 24'h0C0000;
    #2 areset = 1'b1;
    #1;
    chk("async_a", 32'(a), 32'd0);
    chk("async_valid", 32'(a_valid), 32'd0);
    chk("async_busy", 32'(sweep_busy), 32'd0);
    chk("async_done", 32'(sweep_done), 32'd0);
    chk("async_ack", 32'(ftw_ack), 32'd0);
    @(posedge clk);
    #1;
    areset = 1'b0; ftw_load = 1'b0;
    step();
    chk("post_rst_v0", 32'(a_valid), 32'd0);
    step();
    chk("post_rst_a1", 32'(a), 32'h155);
    step();
    chk("post_rst_ftw0", 32'(a), 32'h155);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
